// File: rtl/i2c_write_master.sv
// Bit-level I2C write engine: START, three MSB-first bytes with an ACK slot
// after each, then STOP. Reports completion and the combined ACK status.
module i2c_write_master #(
    parameter int unsigned QTR_DIV = 125
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [23:0] i2c_data,
    output logic        done,
    output logic        ack,
    output logic        busy,
    output logic        i2c_sclk,
    inout  wire         i2c_sdat
);

    localparam int unsigned NUM_BYTES = 3;
    localparam int unsigned CNT_W     = 10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_ACK,
        S_STOP
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         phase_q, phase_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [2:0]         bit_q,   bit_d;
    logic [1:0]         byte_q,  byte_d;
    logic [23:0]        shift_q, shift_d;
    logic               acc_q,   acc_d;
    logic               done_q,  done_d;
    logic               ack_q,   ack_d;
    logic               scl_q,   scl_d;
    logic               oe_q,    oe_d;
    logic               tick;
    logic               sda_low;

    // ACK sample: anything other than a clean 0 (including X/Z) counts as NACK
    always_comb begin
        sda_low = 1'b0;
        if (i2c_sdat == 1'b0) begin
            sda_low = 1'b1;
        end
    end

    // Next-state logic; pin levels are derived from the next state so that
    // the registered SCL/SDA-enable line up with the registered state
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        shift_d = shift_q;
        acc_d   = acc_q;
        ack_d   = ack_q;
        tick    = (cnt_q == CNT_W'(QTR_DIV - 1));

        if (state_q == S_IDLE) begin
            cnt_d = '0;
            if (start) begin
                state_d = S_START;
                phase_d = '0;
                shift_d = i2c_data;
                bit_d   = '0;
                byte_d  = '0;
                acc_d   = 1'b0;
                ack_d   = 1'b0;
            end
        end else begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
            if (tick) begin
                phase_d = phase_q + 2'd1;
                if (state_q == S_ACK && phase_q == 2'd2) begin
                    acc_d = sda_low;
                end
                if (phase_q == 2'd3) begin
                    case (state_q)
                        S_START: begin
                            state_d = S_DATA;
                            bit_d   = '0;
                        end
                        S_DATA: begin
                            shift_d = {shift_q[22:0], 1'b0};
                            if (bit_q == 3'd7) begin
                                state_d = S_ACK;
                            end else begin
                                bit_d = bit_q + 3'd1;
                            end
                        end
                        S_ACK: begin
                            if (acc_q && byte_q != 2'(NUM_BYTES - 1)) begin
                                state_d = S_DATA;
                                byte_d  = byte_q + 2'd1;
                                bit_d   = '0;
                            end else begin
                                state_d = S_STOP;
                            end
                        end
                        S_STOP: begin
                            state_d = S_IDLE;
                            ack_d   = acc_q;
                        end
                        default: state_d = S_IDLE;
                    endcase
                end
            end
        end

        scl_d = 1'b1;
        oe_d  = 1'b0;
        case (state_d)
            S_START: begin
                scl_d = ~phase_d[1];
                oe_d  = (phase_d != 2'd0);
            end
            S_DATA: begin
                scl_d = phase_d[1];
                oe_d  = ~shift_d[23];
            end
            S_ACK: begin
                scl_d = phase_d[1];
                oe_d  = 1'b0;
            end
            S_STOP: begin
                scl_d = (phase_d != 2'd0);
                oe_d  = (phase_d != 2'd3);
            end
            default: begin
                scl_d = 1'b1;
                oe_d  = 1'b0;
            end
        endcase
        done_d = (state_d == S_IDLE);
    end

    // State and pin registers; reset abandons any transfer without a STOP
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            phase_q <= '0;
            cnt_q   <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            shift_q <= '0;
            acc_q   <= 1'b0;
            done_q  <= 1'b1;
            ack_q   <= 1'b0;
            scl_q   <= 1'b1;
            oe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            shift_q <= shift_d;
            acc_q   <= acc_d;
            done_q  <= done_d;
            ack_q   <= ack_d;
            scl_q   <= scl_d;
            oe_q    <= oe_d;
        end
    end

    assign done     = done_q;
    assign busy     = ~done_q;
    assign ack      = ack_q;
    assign i2c_sclk = scl_q;
    assign i2c_sdat = oe_q ? 1'b0 : 1'bz;

endmodule
